scoreboard_reg_file: RTL and testbench

- Parametrised register file for the pipelined core: width, depth and number of read ports are configurable, and register 0 is hardwired to zero.
- Adds write-to-read bypass and a per-register busy scoreboard: issue marks a destination pending, writeback clears it.
- Decode uses this to detect RAW hazards and to stall on WAW hazards.
- Sits between decode (read/issue side) and writeback (write side).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 76 +++++++
 rtl/scoreboard_reg_file.sv | 88 ++++++++
 tb/tb_scoreboard_reg_file.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: address-width helper,
// the hardwired zero-register index and the default scoreboard vector type.
package rf_pkg;

  // Address width needed to index nregs registers (at least one bit).
  function automatic int rf_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Register index that always reads as zero and never becomes busy.
  localparam int ZERO_REG = 0;

  // Default register count and its matching scoreboard vector.
  localparam int DEF_NREGS = 32;
  typedef logic [DEF_NREGS-1:0] sb_vec_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback
// clears it, flush cancels everything. Also answers per-port busy lookups.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic                iss_ready,
  output logic                busy_any
);

  localparam bit BYP = (BYPASS != 0);

  typedef logic [NREGS-1:0] busy_vec_t;

  busy_vec_t busy_q;
  busy_vec_t busy_d;

  // A pending WAW stalls issue unless the older producer retires this cycle.
  always_comb begin
    iss_ready = ~busy_q[iss_rd] | (we & (wa == iss_rd));
  end

  // Next busy state: flush beats everything, then an accepted issue beats a
  // same-register writeback clear so the new producer stays tracked.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (we) begin
        busy_d[wa] = 1'b0;
      end
      if (iss_valid && iss_ready && (iss_rd != AW'(ZERO_REG))) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy vector register; async reset drops all pending producers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Summary flag comes from registered state only.
  always_comb begin
    busy_any = |busy_q;
  end

  // Per-port busy lookup; a forwarded writeback hides the busy bit.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd_busy
    logic [AW-1:0] addr;
    logic          hit;
    assign addr       = rd_addr[k*AW +: AW];
    assign hit        = BYP & we & (wa == addr);
    assign rd_busy[k] = busy_q[addr] & ~hit;
  end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Register file with configurable width/depth/read ports, hardwired zero
// register, optional write-to-read bypass and a busy scoreboard for decode.
module scoreboard_reg_file
  import rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  flush,
  output logic                  busy_any
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Writeback updates the storage array; register 0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != AW'(ZERO_REG))) begin
      regs_d[wa] = wd;
    end
    regs_d[ZERO_REG] = '0;
  end

  // Storage array; async reset clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero register, then forwarded writeback, then stored value.
  // Forwarding is gated by rst_n so reads stay zero while in reset.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    assign addr = rd_addr[k*AW +: AW];
    always_comb begin
      if (addr == AW'(ZERO_REG)) begin
        data = '0;
      end else if (BYP && rst_n && we && (wa == addr)) begin
        data = wd;
      end else begin
        data = regs_q[addr];
      end
    end
    assign rd_data[k*XLEN +: XLEN] = data;
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .iss_ready (iss_ready),
    .busy_any  (busy_any)
  );

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Bench for scoreboard_reg_file: a bypassing and a non-bypassing 32x32
// instance share stimulus; a 16x64 three-port instance covers port aliasing.
module tb_scoreboard_reg_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared 32x32 stimulus ----------------
  logic [9:0]  rd_addr;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        iss_ready_a, iss_ready_b;
  logic        busy_any_a, busy_any_b;

  // ---------------- wide 16x64x3 stimulus ----------------
  logic [11:0]  w_rd_addr;
  logic [191:0] w_rd_data;
  logic [2:0]   w_rd_busy;
  logic         w_we;
  logic [3:0]   w_wa;
  logic [63:0]  w_wd;
  logic         w_iss_valid;
  logic [3:0]   w_iss_rd;
  logic         w_iss_ready;
  logic         w_flush;
  logic         w_busy_any;

  scoreboard_reg_file #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(iss_ready_a), .flush(flush), .busy_any(busy_any_a)
  );

  scoreboard_reg_file #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_ready(iss_ready_b), .flush(flush), .busy_any(busy_any_b)
  );

  scoreboard_reg_file #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
    .rd_busy(w_rd_busy), .we(w_we), .wa(w_wa), .wd(w_wd), .iss_valid(w_iss_valid),
    .iss_rd(w_iss_rd), .iss_ready(w_iss_ready), .flush(w_flush), .busy_any(w_busy_any)
  );

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model (32x32 instances) ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && (wa == a)) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_rbusy(input logic [4:0] a, input bit byp);
    return m_busy[a] && !(byp && we && (wa == a));
  endfunction

  function automatic bit m_ready();
    return !m_busy[iss_rd] || (we && (wa == iss_rd));
  endfunction

  function automatic bit m_any();
    bit r = 1'b0;
    for (int i = 0; i < 32; i++) r |= m_busy[i];
    return r;
  endfunction

  // Advance one clock: apply the architectural rules to the model at posedge.
  task automatic step();
    logic [31:0] nr [32];
    bit          nb [32];
    bit          rdy;
    rdy = m_ready();
    nr  = m_regs;
    nb  = m_busy;
    if (we && wa != 5'd0) nr[wa] = wd;
    if (flush) begin
      for (int i = 0; i < 32; i++) nb[i] = 1'b0;
    end else begin
      if (we) nb[wa] = 1'b0;
      if (iss_valid && rdy && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
    end
    @(posedge clk);
    m_regs = nr;
    m_busy = nb;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rd_addr = '0; we = 1'b0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    w_rd_addr = '0; w_we = 1'b0; w_wa = '0; w_wd = '0;
    w_iss_valid = 1'b0; w_iss_rd = '0; w_flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    #2;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
        errors++;
        $display("FAIL reset_rd_data addr=%0d: got a=%h b=%h expected 0", a, rd_data_a, rd_data_b);
      end
      checks++;
      if (rd_busy_a !== 2'b00 || rd_busy_b !== 2'b00 || busy_any_a !== 1'b0 || busy_any_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy addr=%0d: got rd_busy=%b/%b any=%b/%b expected 0", a, rd_busy_a, rd_busy_b, busy_any_a, busy_any_b);
      end
    end
    checks++;
    if (iss_ready_a !== 1'b1 || iss_ready_b !== 1'b1 || w_iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_iss_ready: got %b/%b/%b expected 1", iss_ready_a, iss_ready_b, w_iss_ready);
    end
    // Write and issue while in reset must have no effect.
    @(negedge clk);
    rd_addr = {5'd0, 5'd5}; we = 1'b1; wa = 5'd5; wd = 32'hAAAA_5555;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_bypass: got %h expected 0", rd_data_a[31:0]);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    rd_addr = {5'd9, 5'd5};
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'h0 || rd_busy_a[1] !== 1'b0 || busy_any_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_ops: got data=%h busy9=%b any=%b expected 0/0/0", rd_data_a[31:0], rd_busy_a[1], busy_any_a);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data_a[31:0]);
    end
    checks++;
    if (rd_data_b[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle: got %h expected 0", rd_data_b[31:0]);
    end
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'hDEAD_BEEF || rd_data_b[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_next_cycle: got a=%h b=%h expected deadbeef", rd_data_a[31:0], rd_data_b[31:0]);
    end
    step();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
      errors++;
      $display("FAIL zero_write_same: got a=%h b=%h expected 0", rd_data_a, rd_data_b);
    end
    step();
    we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    checks++;
    if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0 || iss_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL zero_read: got data=%h ready=%b expected 0/1", rd_data_a, iss_ready_a);
    end
    step();
    iss_valid = 1'b0;
    #1;
    checks++;
    if (busy_any_a !== 1'b0 || busy_any_b !== 1'b0 || rd_busy_a !== 2'b00) begin
      errors++;
      $display("FAIL zero_issue: got any=%b/%b rd_busy=%b expected 0", busy_any_a, busy_any_b, rd_busy_a);
    end
    step();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++;
    if (iss_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL sb_first_ready: got %b expected 1", iss_ready_a);
    end
    step();
    iss_valid = 1'b0; rd_addr = {5'd3, 5'd7};
    #1;
    checks++;
    if (rd_busy_a !== 2'b01 || rd_busy_b !== 2'b01 || busy_any_a !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_after_issue: got rd_busy=%b/%b any=%b expected 01/01/1", rd_busy_a, rd_busy_b, busy_any_a);
    end
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++;
    if (iss_ready_a !== 1'b0 || iss_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL sb_waw_stall: got %b/%b expected 0", iss_ready_a, iss_ready_b);
    end
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0777;
    #1;
    checks++;
    if (iss_ready_a !== 1'b1 || iss_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL sb_waw_retire_ready: got %b/%b expected 1", iss_ready_a, iss_ready_b);
    end
    checks++;
    if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_bypass: got a=%b b=%b expected 0/1", rd_busy_a[0], rd_busy_b[0]);
    end
    step();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    checks++;
    if (rd_busy_a[0] !== 1'b1 || busy_any_a !== 1'b1 || rd_data_a[31:0] !== 32'h0000_0777) begin
      errors++;
      $display("FAIL sb_set_wins: got busy=%b any=%b data=%h expected 1/1/777", rd_busy_a[0], busy_any_a, rd_data_a[31:0]);
    end
    step();
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0888;
    step();
    we = 1'b0;
    #1;
    checks++;
    if (busy_any_a !== 1'b0 || busy_any_b !== 1'b0 || rd_busy_a !== 2'b00) begin
      errors++;
      $display("FAIL sb_retire_clears: got any=%b/%b rd_busy=%b expected 0", busy_any_a, busy_any_b, rd_busy_a);
    end
    step();
  endtask

  task automatic test_flush();
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_rd = 5'd9;
    step();
    flush = 1'b1; iss_rd = 5'd12;
    step();
    flush = 1'b0; iss_valid = 1'b0; rd_addr = {5'd3, 5'd12};
    #1;
    checks++;
    if (busy_any_a !== 1'b0 || busy_any_b !== 1'b0 || rd_busy_a !== 2'b00 || rd_busy_b !== 2'b00) begin
      errors++;
      $display("FAIL flush_clears: got any=%b/%b rd_busy=%b/%b expected 0", busy_any_a, busy_any_b, rd_busy_a, rd_busy_b);
    end
    step();
  endtask

  task automatic test_async_reset();
    we = 1'b1; wa = 5'd4; wd = 32'h0000_1234;
    step();
    we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd6;
    step();
    iss_valid = 1'b0; rd_addr = {5'd6, 5'd4};
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'h0000_1234 || busy_any_a !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: got data=%h any=%b expected 1234/1", rd_data_a[31:0], busy_any_a);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'h0 || rd_data_b[31:0] !== 32'h0 || busy_any_a !== 1'b0 || rd_busy_a !== 2'b00) begin
      errors++;
      $display("FAIL areset_immediate: got data=%h/%h any=%b rd_busy=%b expected 0", rd_data_a[31:0], rd_data_b[31:0], busy_any_a, rd_busy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd4; wd = 32'h0000_0055;
    step();
    we = 1'b0;
    #1;
    checks++;
    if (rd_data_a[31:0] !== 32'h0000_0055 || busy_any_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_post_write: got data=%h any=%b expected 55/0", rd_data_a[31:0], busy_any_a);
    end
    step();
  endtask

  task automatic test_wide_alias();
    logic [63:0] v;
    v = 64'h0123_4567_89AB_CDEF;
    w_we = 1'b1; w_wa = 4'd2; w_wd = v; w_rd_addr = {4'd2, 4'd2, 4'd2};
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (w_rd_data[k*64 +: 64] !== v) begin
        errors++;
        $display("FAIL wide_bypass port%0d: got %h expected %h", k, w_rd_data[k*64 +: 64], v);
      end
    end
    step();
    w_we = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (w_rd_data[k*64 +: 64] !== v || w_rd_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL wide_stored port%0d: got %h busy=%b expected %h/0", k, w_rd_data[k*64 +: 64], w_rd_busy[k], v);
      end
    end
    step();
  endtask

  task automatic test_random(input int n);
    logic [4:0] a;
    logic [31:0] e;
    for (int c = 0; c < n; c++) begin
      we        = ($urandom_range(0, 2) == 0);
      wa        = 5'($urandom_range(0, 31));
      wd        = $urandom;
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wa = iss_rd;
      flush     = ($urandom_range(0, 19) == 0);
      rd_addr   = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wa;
      exp_q.push_back(m_rd(rd_addr[4:0], 1'b1));
      #1;
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        checks++;
        if (rd_data_a[k*32 +: 32] !== m_rd(a, 1'b1) || rd_data_b[k*32 +: 32] !== m_rd(a, 1'b0)) begin
          errors++;
          $display("FAIL rand_rd_data c=%0d p%0d a=%0d: got %h/%h expected %h/%h", c, k, a,
                   rd_data_a[k*32 +: 32], rd_data_b[k*32 +: 32], m_rd(a, 1'b1), m_rd(a, 1'b0));
        end
        checks++;
        if (rd_busy_a[k] !== m_rbusy(a, 1'b1) || rd_busy_b[k] !== m_rbusy(a, 1'b0)) begin
          errors++;
          $display("FAIL rand_rd_busy c=%0d p%0d a=%0d: got %b/%b expected %b/%b", c, k, a,
                   rd_busy_a[k], rd_busy_b[k], m_rbusy(a, 1'b1), m_rbusy(a, 1'b0));
        end
      end
      checks++;
      if (iss_ready_a !== m_ready() || iss_ready_b !== m_ready() ||
          busy_any_a !== m_any() || busy_any_b !== m_any()) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d: got ready=%b/%b any=%b/%b expected %b/%b", c,
                 iss_ready_a, iss_ready_b, busy_any_a, busy_any_b, m_ready(), m_any());
      end
      e = exp_q.pop_front();
      checks++;
      if (rd_data_a[31:0] !== e) begin
        errors++;
        $display("FAIL rand_queue c=%0d: got %h expected %h", c, rd_data_a[31:0], e);
      end
      step();
    end
    idle_inputs();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_async_reset();
    test_wide_alias();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
